// File: rtl/graph_mem_arbiter.sv
// Round-robin burst read scheduler sharing one memory read port between the
// vertex loader (V) and the edge loader (E); returns words to the burst owner.
module graph_mem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              v_req,
  input  logic [ADDR_W-1:0] v_base,
  input  logic [LEN_W-1:0]  v_len,
  input  logic              e_req,
  input  logic [ADDR_W-1:0] e_base,
  input  logic [LEN_W-1:0]  e_len,
  output logic              v_grant,
  output logic              e_grant,
  output logic [DATA_W-1:0] rd_data,
  output logic              v_valid,
  output logic              e_valid,
  output logic              v_done,
  output logic              e_done,
  output logic              busy,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t             state, state_nxt;
  logic               owner_e;
  logic               last_e;
  logic [ADDR_W-1:0]  cur_addr;
  logic [LEN_W-1:0]   remaining;
  logic               pick_v, pick_e, pick_any;
  logic [LEN_W-1:0]   win_len;
  logic [ADDR_W-1:0]  win_base;
  logic               word_in, last_word;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(MAX_BURST)) return LEN_W'(MAX_BURST);
    return len;
  endfunction

  // On a tie the loader that did not own the previous burst wins.
  always_comb begin
    pick_v    = v_req && (!e_req || last_e);
    pick_e    = e_req && (!v_req || !last_e);
    pick_any  = pick_v || pick_e;
    win_len   = pick_e ? clamp_len(e_len) : clamp_len(v_len);
    win_base  = pick_e ? e_base : v_base;
    word_in   = (state == WAIT) && mem_rvalid;
    last_word = word_in && (remaining == LEN_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any && (win_len != '0)) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (word_in) state_nxt = last_word ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign mem_rd   = (state == ISSUE);
  assign mem_addr = cur_addr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      owner_e   <= 1'b0;
      last_e    <= 1'b1;
      cur_addr  <= '0;
      remaining <= '0;
      rd_data   <= '0;
      v_grant   <= 1'b0;
      e_grant   <= 1'b0;
      v_valid   <= 1'b0;
      e_valid   <= 1'b0;
      v_done    <= 1'b0;
      e_done    <= 1'b0;
    end else begin
      v_grant <= 1'b0;
      e_grant <= 1'b0;
      v_valid <= 1'b0;
      e_valid <= 1'b0;
      v_done  <= 1'b0;
      e_done  <= 1'b0;
      if ((state == IDLE) && pick_any) begin
        v_grant   <= pick_v;
        e_grant   <= pick_e;
        owner_e   <= pick_e;
        last_e    <= pick_e;
        cur_addr  <= win_base;
        remaining <= win_len;
        // A zero-length burst completes in its grant cycle without touching memory.
        if (win_len == '0) begin
          v_done <= pick_v;
          e_done <= pick_e;
        end
      end
      if (word_in) begin
        rd_data   <= mem_rdata;
        v_valid   <= !owner_e;
        e_valid   <= owner_e;
        cur_addr  <= cur_addr + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
        if (last_word) begin
          v_done <= !owner_e;
          e_done <= owner_e;
        end
      end
    end
  end

endmodule

// File: tb/tb_graph_mem_arbiter.sv
// Bench for graph_mem_arbiter: directed and random bursts against a
// burst-level model of arbitration order, address sequence and returned data.
module tb_graph_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       v_req = 1'b0, e_req = 1'b0;
  logic [7:0] v_base = '0, e_base = '0;
  logic [4:0] v_len = '0, e_len = '0;
  logic       v_grant, e_grant, v_valid, e_valid, v_done, e_done, busy, mem_rd;
  logic [7:0] rd_data, mem_addr;
  logic [7:0] mem_rdata = '0;
  logic       mem_rvalid = 1'b0;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  graph_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(16), .LEN_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .v_req(v_req), .v_base(v_base), .v_len(v_len),
    .e_req(e_req), .e_base(e_base), .e_len(e_len),
    .v_grant(v_grant), .e_grant(e_grant), .rd_data(rd_data),
    .v_valid(v_valid), .e_valid(e_valid), .v_done(v_done), .e_done(e_done),
    .busy(busy), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  logic [7:0] mem_img [256];
  int lat = 1;
  int inj_req = 0, inj_seen = 0;
  int cyc = 0;
  typedef struct { logic [7:0] a; int due; } rd_t;
  rd_t pend[$];

  logic [7:0] addr_q[$], vq[$], eq[$];
  logic       grant_q[$];
  int         vcyc_q[$], gcyc_q[$], rdcyc_q[$];
  int rd_cnt = 0, vdone = 0, edone = 0, vdav = 0, edav = 0, busy_cnt = 0, viol = 0, gd_same = 0;
  logic own = 1'b0;

  // Memory responder and event monitor, both on the falling edge.
  always @(negedge clk) begin
    cyc++;
    mem_rvalid = 1'b0;
    if (!reset_n) pend.delete();
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_img[pend[0].a];
      pend.delete(0);
    end else if (inj_req != inj_seen) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 8'h3C;
      inj_seen   = inj_req;
    end
    if (mem_rd) begin
      pend.push_back('{a: mem_addr, due: cyc + lat});
      addr_q.push_back(mem_addr);
      rdcyc_q.push_back(cyc);
      rd_cnt++;
    end
    if (v_grant) begin grant_q.push_back(1'b0); gcyc_q.push_back(cyc); own = 1'b0; end
    if (e_grant) begin grant_q.push_back(1'b1); gcyc_q.push_back(cyc); own = 1'b1; end
    if (v_grant && e_grant) viol++;
    if (v_valid && e_valid) viol++;
    if (busy && ((!own && (e_valid || e_done || e_grant)) || (own && (v_valid || v_done || v_grant)))) viol++;
    if (v_valid) begin vq.push_back(rd_data); vcyc_q.push_back(cyc); end
    if (e_valid) eq.push_back(rd_data);
    if (v_done) vdone++;
    if (e_done) edone++;
    if (v_done && v_valid) vdav++;
    if (e_done && e_valid) edav++;
    if ((v_grant && v_done) || (e_grant && e_done)) gd_same++;
    if (busy) busy_cnt++;
  end

  int m_g, m_addr, m_v, m_e, m_rd, m_vdone, m_edone, m_vdav, m_edav, m_busy, m_viol, m_gd;
  logic model_last = 1'b1;

  task automatic check(input string tag, input int obs, input int want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic mark();
    m_g = grant_q.size(); m_addr = addr_q.size(); m_v = vq.size(); m_e = eq.size();
    m_rd = rd_cnt; m_vdone = vdone; m_edone = edone; m_vdav = vdav; m_edav = edav;
    m_busy = busy_cnt; m_viol = viol; m_gd = gd_same;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, int'({v_grant, e_grant, v_valid, e_valid, v_done, e_done, busy, mem_rd}), 0);
    check({tag, "_data"}, int'({rd_data, mem_addr}), 0);
  endtask

  function automatic int clampi(input logic [4:0] l);
    return (l > 5'd16) ? 16 : int'(l);
  endfunction

  // Issue one (or two simultaneous) burst requests and compare against the model.
  task automatic go(input string tag, input logic do_v, input logic do_e,
                    input logic [7:0] vb, input logic [4:0] vl,
                    input logic [7:0] eb, input logic [4:0] el, input int lt);
    logic       first;
    int         elv, ele, t, n;
    logic [7:0] b;
    logic       who;
    logic [7:0] ea[$], ev[$], ee[$];
    logic       eg[$];
    lat = lt;
    mark();
    v_base = vb; v_len = vl; e_base = eb; e_len = el;
    v_req = do_v; e_req = do_e;
    for (t = 0; t < 400; t++) begin
      tick();
      if (v_grant) v_req = 1'b0;
      if (e_grant) e_req = 1'b0;
      if (!v_req && !e_req && !busy && (vdone - m_vdone) == int'(do_v) &&
          (edone - m_edone) == int'(do_e)) break;
    end
    v_req = 1'b0; e_req = 1'b0;
    check({tag, "_timeout"}, int'(t < 400), 1);
    tick();
    first = (do_v && do_e) ? !model_last : do_e;
    model_last = (do_v && do_e) ? !first : first;
    elv = do_v ? clampi(vl) : 0;
    ele = do_e ? clampi(el) : 0;
    for (int k = 0; k < 2; k++) begin
      who = (k == 0) ? first : !first;
      if ((k == 1) && !(do_v && do_e)) break;
      eg.push_back(who);
      b = who ? eb : vb;
      n = who ? ele : elv;
      for (int i = 0; i < n; i++) begin
        ea.push_back(8'(int'(b) + i));
        if (who) ee.push_back(mem_img[8'(int'(b) + i)]);
        else     ev.push_back(mem_img[8'(int'(b) + i)]);
      end
    end
    check({tag, "_ngrant"}, grant_q.size() - m_g, eg.size());
    for (int i = 0; i < eg.size(); i++)
      if (m_g + i < grant_q.size()) check({tag, "_grant_who"}, int'(grant_q[m_g + i]), int'(eg[i]));
    check({tag, "_nrd"}, rd_cnt - m_rd, ea.size());
    for (int i = 0; i < ea.size(); i++)
      if (m_addr + i < addr_q.size()) check({tag, "_addr"}, int'(addr_q[m_addr + i]), int'(ea[i]));
    check({tag, "_nv"}, vq.size() - m_v, ev.size());
    for (int i = 0; i < ev.size(); i++)
      if (m_v + i < vq.size()) check({tag, "_vdata"}, int'(vq[m_v + i]), int'(ev[i]));
    check({tag, "_ne"}, eq.size() - m_e, ee.size());
    for (int i = 0; i < ee.size(); i++)
      if (m_e + i < eq.size()) check({tag, "_edata"}, int'(eq[m_e + i]), int'(ee[i]));
    check({tag, "_vdone"}, vdone - m_vdone, int'(do_v));
    check({tag, "_edone"}, edone - m_edone, int'(do_e));
    check({tag, "_done_w_valid"}, (vdav - m_vdav) + (edav - m_edav),
          int'(do_v && elv > 0) + int'(do_e && ele > 0));
    check({tag, "_grant_w_done"}, gd_same - m_gd,
          int'(do_v && elv == 0) + int'(do_e && ele == 0));
    check({tag, "_busy"}, busy_cnt - m_busy, (elv + ele) * (1 + lt));
    check({tag, "_owner_viol"}, viol - m_viol, 0);
  endtask

  int               t;
  int               gseen;
  logic [7:0]       t1_data [4];
  logic [7:0]       t1_a;

  initial begin
    for (int a = 0; a < 256; a++) mem_img[a] = 8'(a ^ 8'hA5);

    // Reset state.
    reset_n = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    reset_n = 1'b1;
    model_last = 1'b1;

    // Single vertex burst with latency 1, including cycle-level timing.
    go("single", 1'b1, 1'b0, 8'h10, 5'd4, 8'h00, 5'd0, 1);
    t1_data = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};
    for (int k = 0; k < 4; k++) begin
      if (m_v + k < vq.size()) check("single_const_data", int'(vq[m_v + k]), int'(t1_data[k]));
      t1_a = 8'(8'h10 + k);
      if (m_addr + k < addr_q.size()) check("single_const_addr", int'(addr_q[m_addr + k]), int'(t1_a));
      if (m_v + k < vcyc_q.size() && m_g < gcyc_q.size())
        check("single_valid_cycle", vcyc_q[m_v + k] - gcyc_q[m_g], 2 * k + 2);
    end
    if (m_addr < rdcyc_q.size() && m_g < gcyc_q.size())
      check("single_first_rd_cycle", rdcyc_q[m_addr], gcyc_q[m_g]);

    // Contention: both requests held from reset, each len 2.
    reset_n = 1'b0;
    v_req = 1'b1; e_req = 1'b1;
    v_base = 8'h20; e_base = 8'h40; v_len = 5'd2; e_len = 5'd2;
    lat = 1;
    repeat (2) tick();
    reset_n = 1'b1;
    mark();
    gseen = 0;
    for (t = 0; t < 200; t++) begin
      tick();
      if (v_grant || e_grant) gseen++;
      if (gseen == 4) begin v_req = 1'b0; e_req = 1'b0; end
      if (gseen >= 4 && !busy && (edone - m_edone) == 2) break;
    end
    v_req = 1'b0; e_req = 1'b0;
    check("cont_timeout", int'(t < 200), 1);
    tick();
    check("cont_ngrant", grant_q.size() - m_g, 4);
    for (int i = 0; i < 4; i++)
      if (m_g + i < grant_q.size()) check("cont_order", int'(grant_q[m_g + i]), i % 2);
    for (int i = 0; i < 8; i++)
      if (m_addr + i < addr_q.size())
        check("cont_addr", int'(addr_q[m_addr + i]), ((i / 2) % 2 == 0 ? 8'h20 : 8'h40) + (i % 2));
    check("cont_nv", vq.size() - m_v, 4);
    check("cont_ne", eq.size() - m_e, 4);
    for (int i = 0; i < 4; i++) begin
      if (m_v + i < vq.size()) check("cont_vdata", int'(vq[m_v + i]), int'(mem_img[8'h20 + i % 2]));
      if (m_e + i < eq.size()) check("cont_edata", int'(eq[m_e + i]), int'(mem_img[8'h40 + i % 2]));
    end
    check("cont_viol", viol - m_viol, 0);
    check("cont_busy", busy_cnt - m_busy, 16);
    model_last = 1'b1;

    // Address wrap, zero length, clamped length.
    go("wrap", 1'b0, 1'b1, 8'h00, 5'd0, 8'hFE, 5'd4, 1);
    go("len0", 1'b1, 1'b0, 8'h33, 5'd0, 8'h00, 5'd0, 1);
    go("len20", 1'b1, 1'b0, 8'h80, 5'd20, 8'h00, 5'd0, 1);

    // Spurious mem_rvalid in IDLE, then a latency-3 burst.
    lat = 3;
    mark();
    inj_req++;
    repeat (4) tick();
    check("spur_nv", vq.size() - m_v, 0);
    check("spur_ne", eq.size() - m_e, 0);
    check("spur_rd_data", int'(rd_data), int'(mem_img[8'h8F]));
    check("spur_busy", int'(busy), 0);
    go("lat3", 1'b1, 1'b0, 8'h30, 5'd5, 8'h00, 5'd0, 3);

    // Reset during the second WAIT of a len-8 burst, late mem_rvalid after release.
    lat = 1;
    mark();
    v_base = 8'h60; v_len = 5'd8; v_req = 1'b1;
    for (t = 0; t < 20; t++) begin
      tick();
      if (v_grant) break;
    end
    v_req = 1'b0;
    check("rst_grant", int'(v_grant), 1);
    repeat (3) tick();
    check("rst_in_wait", int'({busy, mem_rd}), 2);
    reset_n = 1'b0;
    tick();
    check_zero("rst_mid");
    reset_n = 1'b1;
    inj_req++;
    repeat (4) tick();
    check("rst_no_done", vdone - m_vdone, 0);
    check("rst_nv", vq.size() - m_v, 1);
    check("rst_nrd", rd_cnt - m_rd, 2);
    check("rst_late_ignored", int'({rd_data, busy}), 0);
    model_last = 1'b1;
    go("after_rst", 1'b1, 1'b0, 8'h50, 5'd2, 8'h00, 5'd0, 1);

    // Random bursts: single or simultaneous requests, random latency and memory contents.
    for (int a = 0; a < 256; a++) mem_img[a] = 8'($urandom);
    for (int it = 0; it < 24; it++) begin
      int mode;
      mode = $urandom_range(0, 2);
      go($sformatf("rnd%0d", it), mode != 1, mode != 0,
         8'($urandom), 5'($urandom_range(0, 20)),
         8'($urandom), 5'($urandom_range(0, 20)),
         $urandom_range(1, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
